// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional feature macro: DMEM_ARB_RR_EN (round-robin arbitration).
package dmem_arb_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_RD_LAT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_HOST = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between the core and host requesters.
// DMEM_ARB_RR_EN selects round-robin on ties; otherwise core has fixed priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic i_c_req,
  input  logic i_h_req,
  input  logic i_lock,
`ifdef DMEM_ARB_RR_EN
  input  logic i_ptr,
`endif
  output logic o_valid,
  output logic o_port
);

  always_comb begin
    o_valid = 1'b0;
    o_port  = PORT_CORE;
    if (i_lock) begin
      // Host owns the memory while locked; core waits even if host is idle.
      o_valid = i_h_req;
      o_port  = PORT_HOST;
    end else if (i_c_req && i_h_req) begin
      o_valid = 1'b1;
`ifdef DMEM_ARB_RR_EN
      o_port  = ~i_ptr;
`else
      o_port  = PORT_CORE;
`endif
    end else if (i_c_req) begin
      o_valid = 1'b1;
      o_port  = PORT_CORE;
    end else if (i_h_req) begin
      o_valid = 1'b1;
      o_port  = PORT_HOST;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the single-port data memory.
// Optional feature macro: DMEM_ARB_RR_EN (round-robin pointer instead of core priority).
//
// state | meaning
// IDLE  | sample requests, latch winner's address/data/we
// ISSUE | strobe memory, pulse winner's gnt
// WAIT  | RD_LAT cycles of read latency, capture on the last
// RESP  | pulse winner's rvalid
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  input  logic              h_lock,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              busy
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_port;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_lock;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [DATA_W-1:0]   r_c_rdata;
  logic [DATA_W-1:0]   r_h_rdata;

  logic                w_sel_valid;
  logic                w_sel_port;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

`ifdef DMEM_ARB_RR_EN
  logic                r_ptr;
`endif

  dmem_arb_pick u_pick (
    .i_c_req (c_req),
    .i_h_req (h_req),
    .i_lock  (r_lock),
`ifdef DMEM_ARB_RR_EN
    .i_ptr   (r_ptr),
`endif
    .o_valid (w_sel_valid),
    .o_port  (w_sel_port)
  );

  assign w_sel_we    = (w_sel_port == PORT_HOST) ? h_we    : c_we;
  assign w_sel_addr  = (w_sel_port == PORT_HOST) ? h_addr  : c_addr;
  assign w_sel_wdata = (w_sel_port == PORT_HOST) ? h_wdata : c_wdata;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_sel_valid) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = r_we ? IDLE : WAIT;
      WAIT:    if (r_wait_cnt == '0) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_port     <= PORT_CORE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_lock     <= 1'b0;
      r_wait_cnt <= '0;
      r_c_rdata  <= '0;
      r_h_rdata  <= '0;
`ifdef DMEM_ARB_RR_EN
      r_ptr      <= PORT_HOST;
`endif
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (!h_lock) r_lock <= 1'b0;
          if (w_sel_valid) begin
            r_port  <= w_sel_port;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            // Lock is taken only by a host grant that asks for it.
            if (w_sel_port == PORT_HOST) r_lock <= h_lock;
`ifdef DMEM_ARB_RR_EN
            r_ptr   <= w_sel_port;
`endif
          end
        end
        ISSUE: r_wait_cnt <= CNT_W'(RD_LAT - 1);
        WAIT: begin
          if (r_wait_cnt == '0) begin
            if (r_port == PORT_HOST) r_h_rdata <= dmem_rdata;
            else                     r_c_rdata <= dmem_rdata;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign c_gnt      = (r_state == ISSUE) && (r_port == PORT_CORE);
  assign h_gnt      = (r_state == ISSUE) && (r_port == PORT_HOST);
  assign c_rvalid   = (r_state == RESP)  && (r_port == PORT_CORE);
  assign h_rvalid   = (r_state == RESP)  && (r_port == PORT_HOST);
  assign dmem_write = (r_state == ISSUE) && r_we;
  assign dmem_read  = (r_state == ISSUE) && !r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign c_rdata    = r_c_rdata;
  assign h_rdata    = r_h_rdata;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a 1-cycle-latency memory model.
module tb_dmem_arbiter;

  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_we, h_req, h_we, h_lock;
  logic [AW-1:0] c_addr, h_addr;
  logic [DW-1:0] c_wdata, h_wdata;
  logic          c_gnt, c_rvalid, h_gnt, h_rvalid;
  logic [DW-1:0] c_rdata, h_rdata;
  logic          dmem_read, dmem_write, busy;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata;

  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] rd_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .h_lock(h_lock),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .busy(busy)
  );

  always @(posedge clk) begin
    if (dmem_write) mem[dmem_addr] <= dmem_wdata;
    if (dmem_read)  rd_q <= mem[dmem_addr];
  end
  assign dmem_rdata = rd_q;

  task automatic apply_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic do_write(input logic host, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    if (host) begin h_req = 1'b1; h_we = 1'b1; h_addr = a; h_wdata = d; end
    else      begin c_req = 1'b1; c_we = 1'b1; c_addr = a; c_wdata = d; end
    @(negedge clk);
    c_req = 1'b0; h_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({c_gnt, h_gnt, c_rvalid, h_rvalid, dmem_read, dmem_write, busy} !== 7'b0) begin
      errors++; $display("FAIL reset_strobes got %b exp 0", {c_gnt, h_gnt, c_rvalid, h_rvalid, dmem_read, dmem_write, busy});
    end
    checks++;
    if ({dmem_addr, dmem_wdata, c_rdata, h_rdata} !== '0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h exp 0", dmem_addr, dmem_wdata, c_rdata, h_rdata);
    end
    // reset asserted during ISSUE of a write
    c_req = 1'b1; c_we = 1'b1; c_addr = 8'h22; c_wdata = 16'h5555;
    @(negedge clk);
    checks++;
    if ({c_gnt, busy} !== 2'b11) begin
      errors++; $display("FAIL pre_reset_issue got %b exp 11", {c_gnt, busy});
    end
    reset = 1'b1; c_req = 1'b0;
    #1;
    checks++;
    if ({c_gnt, dmem_write, busy} !== 3'b0 || dmem_addr !== 8'h00 || dmem_wdata !== 16'h0) begin
      errors++; $display("FAIL mid_reset got %b addr %h wdata %h exp 0", {c_gnt, dmem_write, busy}, dmem_addr, dmem_wdata);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem[8'h22] === 16'h5555) begin
      errors++; $display("FAIL post_reset busy %b mem22 %h exp busy 0 and no write", busy, mem[8'h22]);
    end
  endtask

  task automatic test_core_write();
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b1; c_addr = 8'h05; c_wdata = 16'h1234;
    @(negedge clk);
    checks++;
    if ({c_gnt, h_gnt, dmem_write, dmem_read, busy} !== 5'b10101) begin
      errors++; $display("FAIL cw_issue got %b exp 10101", {c_gnt, h_gnt, dmem_write, dmem_read, busy});
    end
    checks++;
    if (dmem_addr !== 8'h05 || dmem_wdata !== 16'h1234) begin
      errors++; $display("FAIL cw_bus got %h/%h exp 05/1234", dmem_addr, dmem_wdata);
    end
    c_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, dmem_write, c_gnt} !== 3'b0 || dmem_addr !== 8'h05 || mem[8'h05] !== 16'h1234) begin
      errors++; $display("FAIL cw_done got %b addr %h mem %h exp 000 05 1234", {busy, dmem_write, c_gnt}, dmem_addr, mem[8'h05]);
    end
  endtask

  task automatic test_core_read();
    do_write(1'b0, 8'h05, 16'hBEEF);
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h05;
    @(negedge clk);
    checks++;
    if ({c_gnt, dmem_read, dmem_write} !== 3'b110) begin
      errors++; $display("FAIL cr_issue got %b exp 110", {c_gnt, dmem_read, dmem_write});
    end
    c_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, c_rvalid, c_gnt, dmem_read} !== 4'b1000) begin
      errors++; $display("FAIL cr_wait got %b exp 1000", {busy, c_rvalid, c_gnt, dmem_read});
    end
    @(negedge clk);
    checks++;
    if ({c_rvalid, h_rvalid} !== 2'b10 || c_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL cr_resp got %b rdata %h exp 10 BEEF", {c_rvalid, h_rvalid}, c_rdata);
    end
    @(negedge clk);
    checks++;
    if ({busy, c_rvalid} !== 2'b00) begin
      errors++; $display("FAIL cr_idle got %b exp 00", {busy, c_rvalid});
    end
    do_write(1'b0, 8'h06, 16'h1111);
    checks++;
    if (c_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL cr_hold got %h exp BEEF", c_rdata);
    end
  endtask

  task automatic test_host_read();
    do_write(1'b1, 8'h10, 16'hA5A5);
    @(negedge clk);
    h_req = 1'b1; h_we = 1'b0; h_addr = 8'h10;
    @(negedge clk);
    checks++;
    if ({h_gnt, c_gnt, dmem_read} !== 3'b101 || dmem_addr !== 8'h10) begin
      errors++; $display("FAIL hr_issue got %b addr %h exp 101 10", {h_gnt, c_gnt, dmem_read}, dmem_addr);
    end
    h_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({h_rvalid, c_rvalid} !== 2'b10 || h_rdata !== 16'hA5A5 || c_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL hr_resp got %b h %h c %h exp 10 A5A5 BEEF", {h_rvalid, c_rvalid}, h_rdata, c_rdata);
    end
  endtask

  task automatic test_reset_wait();
    @(negedge clk);
    h_req = 1'b1; h_we = 1'b0; h_addr = 8'h10;
    @(negedge clk);
    checks++;
    if (h_gnt !== 1'b1) begin
      errors++; $display("FAIL rw_gnt got %b exp 1", h_gnt);
    end
    h_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, h_rvalid} !== 2'b00 || h_rdata !== 16'h0) begin
      errors++; $display("FAIL rw_reset got %b h_rdata %h exp 00 0000", {busy, h_rvalid}, h_rdata);
    end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({h_rvalid, busy} !== 2'b00) begin
        errors++; $display("FAIL rw_quiet cyc %0d got %b exp 00", i, {h_rvalid, busy});
      end
    end
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h05;
    @(negedge clk);
    checks++;
    if ({c_gnt, dmem_read} !== 2'b11) begin
      errors++; $display("FAIL rw_core_gnt got %b exp 11", {c_gnt, dmem_read});
    end
    c_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (c_rvalid !== 1'b1 || c_rdata !== 16'hBEEF || h_rdata !== 16'h0) begin
      errors++; $display("FAIL rw_core_resp got %b c %h h %h exp 1 BEEF 0000", c_rvalid, c_rdata, h_rdata);
    end
  endtask

  task automatic test_priority();
    logic [3:0] seq;
    logic [3:0] exp_seq;
    int         k;
    seq = '0;
    k   = 0;
`ifdef DMEM_ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b0000;
`endif
    apply_reset();
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b1; c_addr = 8'h20; c_wdata = 16'hC0C0;
    h_req = 1'b1; h_we = 1'b1; h_addr = 8'h21; h_wdata = 16'hD0D0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ((c_gnt & h_gnt) !== 1'b0) begin
        errors++; $display("FAIL pr_both_gnt cyc %0d got 1 exp 0", i);
      end
      if ((c_gnt | h_gnt) && k < 4) begin
        seq[k] = h_gnt;
        k++;
      end
    end
    checks++;
    if (k !== 4 || seq !== exp_seq) begin
      errors++; $display("FAIL pr_seq got n=%0d seq %b exp n=4 seq %b", k, seq, exp_seq);
    end
    c_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({h_gnt, c_gnt} !== 2'b10) begin
      errors++; $display("FAIL pr_loser got %b exp 10", {h_gnt, c_gnt});
    end
    h_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lock();
    int   hcnt;
    logic c_seen;
    hcnt   = 0;
    c_seen = 1'b0;
    apply_reset();
    @(negedge clk);
    h_req = 1'b1; h_lock = 1'b1; h_we = 1'b1; h_addr = 8'h30; h_wdata = 16'h0303;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (h_gnt) begin
        hcnt++;
        if (hcnt == 1) begin c_req = 1'b1; c_we = 1'b1; c_addr = 8'h31; c_wdata = 16'h3131; end
        if (hcnt == 3) h_lock = 1'b0;
        if (hcnt == 4) h_req = 1'b0;
      end
      if (c_gnt && !c_seen) begin
        c_seen = 1'b1;
        checks++;
        if (hcnt !== 4) begin
          errors++; $display("FAIL lk_order host grants before core got %0d exp 4", hcnt);
        end
        c_req = 1'b0;
      end
    end
    checks++;
    if (c_seen !== 1'b1 || hcnt !== 4) begin
      errors++; $display("FAIL lk_totals got core_seen %b host %0d exp 1 4", c_seen, hcnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0; h_lock = 1'b0;
    rd_q  = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_core_write();
    test_core_read();
    test_host_read();
    test_reset_wait();
    test_priority();
    test_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single-port data memory. Shares the memory between the processor control path (core port) and the host loader that preloads and reads back matrices (host port). Issues one memory access at a time, drives the memory read/write strobes and returns read data with a valid pulse. Sits between the core/loader and the data memory.

## Interface
- DATA_W, 16, data bus width.
- ADDR_W, 8, data memory address width.
- RD_LAT, 1, memory read latency in cycles (≥1): dmem_rdata is valid RD_LAT cycles after the cycle dmem_read is high.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- c_req, c_we  in  1  core request, write-enable; held until c_gnt.
- c_addr  in  ADDR_W  core address.
- c_wdata  in  DATA_W  core write data.
- c_gnt  out  1  one-cycle pulse: the core request is issued to memory this cycle.
- c_rvalid  out  1  one-cycle pulse: c_rdata holds the result of the core read.
- c_rdata  out  DATA_W  last core read result; held until the next core read completes.
- h_req, h_we, h_addr, h_wdata, h_gnt, h_rvalid, h_rdata  same as the c_* ports, for the host.
- h_lock  in  1  host requests exclusive ownership across consecutive accesses.
- dmem_read, dmem_write  out  1  memory strobes.
- dmem_addr  out  ADDR_W  memory address.
- dmem_wdata  out  DATA_W  memory write data.
- dmem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any request is pending and eligible, select a winner.
  - Register address, data and we for the winner; go to ISSUE.
  - If no eligible request is pending, stay in IDLE.
- ISSUE (one cycle):
  - Winner's gnt is 1.
  - dmem_write or dmem_read is 1.
  - dmem_addr and dmem_wdata are driven from the registered values.
  - A write goes to IDLE; a read goes to WAIT.
- WAIT: lasts RD_LAT cycles. dmem_rdata is captured into the winner's rdata register on the last WAIT cycle. Then go to RESP.
- RESP (one cycle): winner's rvalid is 1. Then go to IDLE.
- Arbitration (default): fixed priority, core over host.
- Lock:
  - A lock flag is set when the host is granted with h_lock=1.
  - While the flag is set, only the host is eligible.
  - The flag is cleared in IDLE whenever h_lock=0.
- A request withdrawn (req dropped) before selection is never issued. Inputs are sampled only in IDLE.
- Outside ISSUE, dmem strobes are 0. dmem_addr and dmem_wdata hold their last values.
- Reset values:
  - All gnt, rvalid, strobes and busy are 0.
  - rdata registers, dmem_addr and dmem_wdata are 0.
  - State is IDLE, lock flag is 0, round-robin pointer points to host.
- Reset mid-transaction aborts it. No gnt or rvalid follows for the aborted transaction; the requester re-issues it.

## Timing
- Request high in IDLE at cycle T:
  - gnt and strobe at T+1.
  - Write: IDLE again at T+2, so back-to-back writes issue every 2 cycles.
  - Read: rvalid and rdata at T+2+RD_LAT; IDLE at T+3+RD_LAT.
- Simultaneous requests: exactly one gnt per transaction; the loser stays pending and is selected in the next IDLE cycle.
- gnt and rvalid are never high for both ports in the same cycle.

## Configuration
- DMEM_ARB_RR_EN defined:
  - Round-robin arbitration. A 1-bit pointer records the last granted port; on a tie, the other port wins.
  - Reset pointer = host, so the first tie goes to the core.
  - Lock still overrides the pointer.
- DMEM_ARB_RR_EN undefined: fixed core-over-host priority. No pointer register.

## Structure
- Shared package dmem_arb_pkg holds:
  - State encoding constants: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3.
  - Port index constants: PORT_CORE=1'b0, PORT_HOST=1'b1.
  - Default widths.
- One sub-module, dmem_arb_pick: combinational winner select from c_req, h_req, the lock flag and the pointer. Contains the DMEM_ARB_RR_EN conditional.
- Top level holds the FSM, the WAIT latency counter and the capture registers.

## Test plan
- Reset: assert reset mid-run → all outputs 0 immediately; busy=0; state returns to IDLE.
- Core write, c_addr=0x05, c_wdata=0x1234, c_req at T → at T+1: c_gnt=1, dmem_write=1, dmem_addr=0x05, dmem_wdata=0x1234; busy=0 at T+2.
- Core read, RD_LAT=1, memory at 0x05 returns 0xBEEF → c_rvalid=1 at T+3 with c_rdata=0xBEEF; h_rvalid stays 0; c_rdata still 0xBEEF after a subsequent write.
- Both ports requesting continuously, 4 writes → fixed priority: all grants go to the core until c_req drops. With DMEM_ARB_RR_EN: grants go C,H,C,H.
- Host holds h_lock=1 for 3 writes, then a 4th write with h_lock=0, while c_req is held high → 4 host grants, then c_gnt.
- Reset during WAIT of a host read → no h_rvalid; h_rdata=0; a new core request after reset release is granted normally.
